// File: rtl/rom_boot_loader.sv
// Framed byte-stream loader: SYNC, 16-bit word count, little-endian payload words, 8-bit sum.
// Writes words into the instruction ROM and releases the core only after the checksum matches.
`timescale 1ns/1ps
module rom_boot_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  restart,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [31:0]           rom_wdata,
  output logic                  core_rst_n,
  output logic                  load_done,
  output logic                  load_err
);

  typedef enum logic [2:0] {
    S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [32:0]           CAP  = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

  state_e                  state_q;
  logic [15:0]             len_q, cnt_q;
  logic [1:0]              lane_q;
  logic [23:0]             word_q;
  logic [7:0]              sum_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    we_q, rdy_q, done_q, err_q, crst_q;

  logic        acc;
  logic [15:0] len_d, cnt_d;

  assign acc   = rx_valid && rdy_q;
  assign len_d = {rx_data, len_q[7:0]};
  assign cnt_d = cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_SYNC;
      len_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      sum_q   <= '0;
      addr_q  <= BASE;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b0;
    end else if (restart) begin
      // Abort wins over any byte presented this cycle; that byte is dropped.
      state_q <= S_SYNC;
      cnt_q   <= '0;
      lane_q  <= '0;
      sum_q   <= '0;
      addr_q  <= BASE;
      we_q    <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      rdy_q <= !(state_q inside {S_DONE, S_ERR});
      if (we_q) addr_q <= addr_q + 1'b1;
      if (acc) begin
        unique case (state_q)
          S_SYNC: if (rx_data == SYNC_BYTE) begin
            state_q <= S_LEN_LO;
            cnt_q   <= '0;
            lane_q  <= '0;
            sum_q   <= '0;
          end
          S_LEN_LO: begin
            len_q[7:0] <= rx_data;
            state_q    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len_q[15:8] <= rx_data;
            if (len_d == 16'd0) begin
              state_q <= S_CSUM;
            end else if (33'(len_d) > CAP) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              crst_q  <= 1'b0;
              rdy_q   <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            sum_q  <= sum_q + rx_data;
            lane_q <= lane_q + 2'd1;
            word_q <= {rx_data, word_q[23:8]};
            if (lane_q == 2'd3) begin
              we_q    <= 1'b1;
              wdata_q <= {rx_data, word_q};
              cnt_q   <= cnt_d;
              if (cnt_d == len_q) state_q <= S_CSUM;
            end
          end
          S_CSUM: begin
            rdy_q <= 1'b0;
            if (rx_data == sum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              crst_q  <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              crst_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready   = rdy_q;
  assign rom_we     = we_q;
  assign rom_addr   = addr_q;
  assign rom_wdata  = wdata_q;
  assign core_rst_n = crst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: doc/rom_boot_loader.md
Name: rom_boot_loader

Overview:
- Byte-stream program loader sitting directly upstream of the SoC instruction ROM.
- Receives a framed program image from a byte source (UART RX or bench driver) and assembles little-endian 32-bit words.
- Writes the words sequentially into the ROM write port.
- Holds the core in reset until the image is loaded and its checksum verifies; replaces the bench-side memory preload for on-target and self-checking runs.

Parameters:
- ADDR_WIDTH, 12, ROM word-address width; capacity is 2^ADDR_WIDTH words.
- SYNC_BYTE, 8'hA5, frame start marker.
- BASE_ADDR, 0, first ROM word address written.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at a rising edge.
- restart  in  1  single-cycle pulse; aborts/re-arms loader.
- rom_we  out  1  ROM write strobe, one cycle per word.
- rom_addr  out  ADDR_WIDTH  ROM word address.
- rom_wdata  out  32  ROM write data.
- core_rst_n  out  1  active-low reset to core; high only when load succeeded.
- load_done  out  1  image loaded, checksum OK.
- load_err  out  1  checksum mismatch or length overflow.

Behaviour:
- Reset (rst low, async): state SYNC, rx_ready=0 during reset then 1, rom_we=0, rom_addr=BASE_ADDR, rom_wdata=0, core_rst_n=0, load_done=0, load_err=0, all counters and checksum=0.
- Frame: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), 4*N payload bytes (LSB first per word), CSUM byte.
- CSUM equals the 8-bit sum mod 256 of the payload bytes only.
- States: SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- SYNC: byte == SYNC_BYTE -> LEN_LO; any other byte is discarded and the state stays SYNC.
- LEN_LO -> LEN_HI.
- LEN_HI transitions:
  - N == 0 -> CSUM, expected sum 0.
  - N > 2^ADDR_WIDTH - (BASE_ADDR) -> ERR.
  - else -> DATA.
- DATA: byte lane counter 0..3 shifts bytes into the word register and adds each byte to the running sum.
  - On acceptance of lane 3: rom_we=1 the next cycle, rom_wdata=assembled word, rom_addr=current address.
  - Address increments after the write cycle.
  - After the N-th word -> CSUM.
- CSUM: accepted byte == sum -> DONE, else -> ERR.
- rx_ready=1 in SYNC..CSUM and 0 in DONE/ERR. No combinational path from rx_valid to rx_ready.
- Gaps (rx_valid low) stall progress indefinitely; there is no timeout.
- rom_we is a registered single-cycle pulse; consecutive words may write on back-to-back cycles at full byte rate.
- core_rst_n, load_done and load_err are registered and change on the same edge the state enters DONE/ERR:
  - DONE: core_rst_n=1, load_done=1.
  - ERR: load_err=1, core_rst_n=0.
- ROM contents written before an ERR are not cleared.
- restart from any state -> SYNC on the next edge. It clears address, lane, count, sum, load_done and load_err, and drives core_rst_n=0. restart wins over a byte accepted in the same cycle, and that byte is dropped.
- Async reset mid-frame aborts immediately; rom_we deasserts asynchronously.
- Byte arriving in the same cycle rom_we is pulsing is accepted normally.

Test Plan:
- Frame A5 01 00 13 00 00 00 13 -> single rom_we at addr 0, wdata 32'h00000013; load_done=1, core_rst_n=1 the cycle after CSUM accepted.
- Frame with N=3 words 0x00100093, 0x00200113, 0x002081B3 and correct sum:
  - writes at addrs 0, 1, 2 with exact data.
  - back-to-back rx_valid gives rom_we pulses 4 cycles apart.
- Same frame with CSUM off by one -> load_err=1, core_rst_n stays 0, rx_ready=0; then restart pulse -> load_err=0, rx_ready=1, state SYNC; re-send good frame -> load_done=1.
- Bytes 00 FF 5A before A5 01 00 …, N=0 frame A5 00 00 00, and N=0x1001 with ADDR_WIDTH=12 cover the framing corners:
  - leading garbage is ignored.
  - N=0 -> load_done with no rom_we.
  - N=0x1001 -> load_err right after LEN_HI with no rom_we.
- Random rx_valid gaps (30% duty) on the 3-word frame -> identical writes and sum as the gap-free case; no byte lost or duplicated.
- Async rst low for 1 ns mid-DATA (after 6 payload bytes) -> all outputs return to reset values immediately; a full new frame then loads from addr 0 correctly.
